door_sequencer: RTL and testbench
=================================

DOOR_SEQUENCER -- requirements
Module: door_sequencer

Interface
REQ-001 SHALL have parameter TRAVEL_TICKS, default 2: door_clk cycles spent in OPENING and in CLOSING; legal range 1..15.
REQ-002 SHALL have parameter OPEN_TICKS, default 4: door_clk cycles the door dwells fully open; legal range 1..15.
REQ-003 SHALL have parameter MAX_REOPEN, default 3: closing attempts aborted before fault; legal range 1..3.
REQ-004 SHALL have port door_clk  input  1  sequencer tick clock, rising edge active.
REQ-005 SHALL have port button_reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port arrived  input  1  car stopped at a landing; door cycle requested; level, sampled on door_clk.
REQ-007 SHALL have port depart_req  input  1  movement stage wants to leave (goal floor differs from current floor).
REQ-008 SHALL have port obstruction  input  1  door-edge beam interrupted.
REQ-009 SHALL have port weight_limit_exceeded  input  1  car overloaded.
REQ-010 SHALL have port sos_mode  input  1  emergency stop active.
REQ-011 SHALL have port door_open  output  1  door fully open, registered.
REQ-012 SHALL have port depart_ok  output  1  door closed and locked, car may move; registered; consumed by movement stage.
REQ-013 SHALL have port door_state  output  2  FSM state: 00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING.
REQ-014 SHALL have port reopen_fault  output  1  sticky: closing aborted MAX_REOPEN times.

Function
REQ-015 SHALL hold a 4-bit down-counter tmr and a 2-bit saturating counter reopen_cnt; all outputs registered, updated only on rising door_clk.
REQ-016 CLOSED: arrived=1 -> OPENING, tmr <= TRAVEL_TICKS-1; arrived has priority over depart_req on the same edge; otherwise stay, reopen_cnt <= 0.
REQ-017 OPENING: tmr decrements each edge; on the edge with tmr==0 -> OPEN, tmr <= OPEN_TICKS-1; OPENING thus lasts exactly TRAVEL_TICKS cycles.
REQ-018 OPEN: if obstruction, weight_limit_exceeded or sos_mode is 1, tmr reloads OPEN_TICKS-1; else tmr decrements; on the edge with tmr==0 and no hold condition -> CLOSING, tmr <= TRAVEL_TICKS-1.
REQ-019 OPEN with reopen_fault=1: SHALL remain OPEN indefinitely; only reset leaves.
REQ-020 CLOSING: obstruction or weight_limit_exceeded = 1 -> OPENING, tmr <= TRAVEL_TICKS-1, reopen_cnt increments (saturating at 3); else tmr decrements and on the edge with tmr==0 -> CLOSED.
REQ-021 When reopen_cnt reaches MAX_REOPEN, reopen_fault SHALL set on that same edge and stay 1 until reset.
REQ-022 door_open SHALL be 1 iff next state is OPEN (aligned with door_state).
REQ-023 depart_ok SHALL be 1 iff next state is CLOSED and arrived=0, weight_limit_exceeded=0, sos_mode=0, reopen_fault=0; it drops on the same edge the FSM leaves CLOSED.
REQ-024 depart_req SHALL NOT cause a state transition; it affects only depart_ok gating (no door cycle while not arrived).
REQ-025 Obstruction in CLOSED or OPENING SHALL be ignored.

Reset
REQ-026 button_reset=1 SHALL asynchronously force door_state=00, tmr=0, reopen_cnt=0, door_open=0, depart_ok=0, reopen_fault=0, from any state including mid-CLOSING.
REQ-027 After reset release, depart_ok SHALL rise on the first door_clk edge if REQ-023 conditions hold.

Verification
REQ-028 Reset asserted while door_state=10 -> immediately door_state=00, door_open=0, depart_ok=0; first edge after release with inputs 0 -> depart_ok=1.
REQ-029 Defaults, arrived high for one edge E0 -> door_state 01 for edges E0..E1 outputs, 10 for 4 cycles (door_open=1 exactly 4 cycles), 11 for 2, then 00 with depart_ok=1.
REQ-030 obstruction high 3 cycles mid-OPEN -> OPEN extended so door_open lasts 4 cycles past obstruction release.
REQ-031 obstruction pulsed during each of three CLOSING phases -> three returns to 01, reopen_fault=1 on third, door then held at 10 until reset.
REQ-032 weight_limit_exceeded=1 while CLOSED -> depart_ok=0 next edge, door_state stays 00; clears -> depart_ok=1 next edge.
REQ-033 arrived=1 and depart_req=1 same edge in CLOSED -> door_state=01, depart_ok=0.

Source files
------------

// File: rtl/door_sequencer.sv
// ---------------------------------------------------------------------------
// door_sequencer
//   Landing door controller: CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED.
//   The door dwells open for OPEN_TICKS cycles. While it is open, an
//   obstruction, an overload or SOS keeps restarting that dwell. An
//   obstruction or an overload during closing reopens the door. After
//   MAX_REOPEN aborted closings the block latches reopen_fault and parks
//   the door open until reset.
//
// Ports
//   door_clk              in   sequencer tick clock (rising edge)
//   button_reset          in   async active-high reset
//   arrived               in   car at landing, requests a door cycle
//   depart_req            in   movement stage wants to leave (no FSM effect)
//   obstruction           in   door-edge beam interrupted
//   weight_limit_exceeded in   car overloaded
//   sos_mode              in   emergency stop active
//   door_open             out  door fully open (registered)
//   depart_ok             out  door closed and locked, car may move (registered)
//   door_state            out  00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING
//   reopen_fault          out  sticky, closing aborted MAX_REOPEN times
// ---------------------------------------------------------------------------
module door_sequencer #(
   parameter int unsigned TRAVEL_TICKS = 2,
   parameter int unsigned OPEN_TICKS   = 4,
   parameter int unsigned MAX_REOPEN   = 3
) (
   input  logic       door_clk,
   input  logic       button_reset,
   input  logic       arrived,
   input  logic       depart_req,
   input  logic       obstruction,
   input  logic       weight_limit_exceeded,
   input  logic       sos_mode,
   output logic       door_open,
   output logic       depart_ok,
   output logic [1:0] door_state,
   output logic       reopen_fault
);

   typedef enum logic [1:0] {
      CLOSED  = 2'b00,
      OPENING = 2'b01,
      OPEN    = 2'b10,
      CLOSING = 2'b11
   } state_t;

   localparam logic [3:0] TRAVEL_RLD = 4'(TRAVEL_TICKS - 1);
   localparam logic [3:0] OPEN_RLD   = 4'(OPEN_TICKS - 1);
   localparam logic [1:0] MAX_CNT    = 2'(MAX_REOPEN);

   state_t     state_q, state_d;
   logic [3:0] tmr_q, tmr_d;
   logic [1:0] reopen_cnt_q, reopen_cnt_d;
   logic       reopen_fault_q, reopen_fault_d;
   logic       door_open_q, door_open_d;
   logic       depart_ok_q, depart_ok_d;

   logic       hold_open;
   logic       abort_close;

   // depart_req carries no transition; it is accepted and intentionally unused.
   logic       unused_depart_req;
   assign unused_depart_req = depart_req;

   assign hold_open   = obstruction | weight_limit_exceeded | sos_mode;
   assign abort_close = obstruction | weight_limit_exceeded;

   always_comb begin
      state_d        = state_q;
      tmr_d          = tmr_q;
      reopen_cnt_d   = reopen_cnt_q;
      reopen_fault_d = reopen_fault_q;

      unique case (state_q)
         CLOSED: begin
            if (arrived) begin
               state_d = OPENING;
               tmr_d   = TRAVEL_RLD;
            end else begin
               reopen_cnt_d = 2'd0;
            end
         end
         OPENING: begin
            if (tmr_q == 4'd0) begin
               state_d = OPEN;
               tmr_d   = OPEN_RLD;
            end else begin
               tmr_d = tmr_q - 4'd1;
            end
         end
         OPEN: begin
            // A faulted door is parked open. Only reset releases it.
            if (!reopen_fault_q) begin
               if (hold_open) begin
                  tmr_d = OPEN_RLD;
               end else if (tmr_q == 4'd0) begin
                  state_d = CLOSING;
                  tmr_d   = TRAVEL_RLD;
               end else begin
                  tmr_d = tmr_q - 4'd1;
               end
            end
         end
         CLOSING: begin
            if (abort_close) begin
               state_d      = OPENING;
               tmr_d        = TRAVEL_RLD;
               reopen_cnt_d = (reopen_cnt_q == 2'd3) ? 2'd3 : reopen_cnt_q + 2'd1;
            end else if (tmr_q == 4'd0) begin
               state_d = CLOSED;
            end else begin
               tmr_d = tmr_q - 4'd1;
            end
         end
         default: state_d = CLOSED;
      endcase

      // The fault latches on the same edge that the count reaches the limit.
      if (reopen_cnt_d >= MAX_CNT)
         reopen_fault_d = 1'b1;

      // The outputs are registered from next-state so they line up with door_state.
      door_open_d = (state_d == OPEN);
      depart_ok_d = (state_d == CLOSED) & ~arrived & ~weight_limit_exceeded &
                    ~sos_mode & ~reopen_fault_d;
   end

   always_ff @(posedge door_clk or posedge button_reset) begin
      if (button_reset) begin
         state_q        <= CLOSED;
         tmr_q          <= 4'd0;
         reopen_cnt_q   <= 2'd0;
         reopen_fault_q <= 1'b0;
         door_open_q    <= 1'b0;
         depart_ok_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmr_q          <= tmr_d;
         reopen_cnt_q   <= reopen_cnt_d;
         reopen_fault_q <= reopen_fault_d;
         door_open_q    <= door_open_d;
         depart_ok_q    <= depart_ok_d;
      end
   end

   assign door_state   = state_q;
   assign door_open    = door_open_q;
   assign depart_ok    = depart_ok_q;
   assign reopen_fault = reopen_fault_q;

endmodule

// File: tb/tb_door_sequencer.sv
// ---------------------------------------------------------------------------
// tb_door_sequencer
//   Scoreboard bench for door_sequencer with default parameters
//   (TRAVEL_TICKS=2, OPEN_TICKS=4, MAX_REOPEN=3). Each scenario queues one
//   input vector and one expected {door_state, door_open, depart_ok,
//   reopen_fault} word per clock. The outputs are sampled 1 time unit after
//   each rising edge.
// ---------------------------------------------------------------------------
module tb_door_sequencer;

   logic       door_clk = 1'b0;
   logic       button_reset;
   logic       arrived, depart_req, obstruction, weight_limit_exceeded, sos_mode;
   logic       door_open, depart_ok, reopen_fault;
   logic [1:0] door_state;

   door_sequencer dut (
      .door_clk              (door_clk),
      .button_reset          (button_reset),
      .arrived               (arrived),
      .depart_req            (depart_req),
      .obstruction           (obstruction),
      .weight_limit_exceeded (weight_limit_exceeded),
      .sos_mode              (sos_mode),
      .door_open             (door_open),
      .depart_ok             (depart_ok),
      .door_state            (door_state),
      .reopen_fault          (reopen_fault)
   );

   always #5 door_clk = ~door_clk;

   // The input vector is {arrived, depart_req, obstruction, weight_limit_exceeded, sos_mode}.
   localparam logic [4:0] I0  = 5'b00000;
   localparam logic [4:0] ARR = 5'b10000;
   localparam logic [4:0] DEP = 5'b01000;
   localparam logic [4:0] OBS = 5'b00100;
   localparam logic [4:0] WLE = 5'b00010;
   localparam logic [4:0] SOS = 5'b00001;

   localparam logic [1:0] CLD = 2'b00;
   localparam logic [1:0] OPG = 2'b01;
   localparam logic [1:0] OPN = 2'b10;
   localparam logic [1:0] CLG = 2'b11;

   logic [4:0] in_q[$];
   logic [4:0] exp_q[$];
   int         n_chk  = 0;
   int         n_fail = 0;

   function automatic logic [4:0] E(logic [1:0] s, logic o, logic d, logic f);
      return {s, o, d, f};
   endfunction

   function automatic logic [4:0] got();
      return {door_state, door_open, depart_ok, reopen_fault};
   endfunction

   function automatic void sched(logic [4:0] v, logic [4:0] e);
      in_q.push_back(v);
      exp_q.push_back(e);
   endfunction

   // Drive one input vector at the falling edge, then step to just past the
   // next rising edge.
   task automatic tick(input logic [4:0] v);
      @(negedge door_clk);
      {arrived, depart_req, obstruction, weight_limit_exceeded, sos_mode} = v;
      @(posedge door_clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] e;
      button_reset = 1'b1;
      {arrived, depart_req, obstruction, weight_limit_exceeded, sos_mode} = I0;
      exp_q.push_back(E(CLD, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (got() !== e) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected %b", got(), e);
      end
      // depart_ok rises on the first edge after release.
      exp_q.push_back(E(CLD, 0, 1, 0));
      @(negedge door_clk);
      button_reset = 1'b0;
      @(posedge door_clk);
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (got() !== e) begin
         n_fail++;
         $display("FAIL reset_release: got %b expected %b", got(), e);
      end
   endtask

   task automatic test_cycle();
      logic [4:0] e;
      int i = 0;
      sched(ARR, E(OPG, 0, 0, 0));
      sched(I0,  E(OPG, 0, 0, 0));
      repeat (4) sched(I0, E(OPN, 1, 0, 0));
      repeat (2) sched(I0, E(CLG, 0, 0, 0));
      sched(I0, E(CLD, 0, 1, 0));
      while (exp_q.size() != 0) begin
         tick(in_q.pop_front());
         e = exp_q.pop_front();
         n_chk++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL cycle[%0d]: got %b expected %b", i, got(), e);
         end
         i++;
      end
   endtask

   task automatic test_obstruction_open();
      logic [4:0] e;
      int i = 0;
      sched(ARR, E(OPG, 0, 0, 0));
      sched(I0,  E(OPG, 0, 0, 0));
      repeat (2) sched(I0,  E(OPN, 1, 0, 0));
      repeat (3) sched(OBS, E(OPN, 1, 0, 0));
      repeat (3) sched(I0,  E(OPN, 1, 0, 0));
      repeat (2) sched(I0,  E(CLG, 0, 0, 0));
      sched(I0, E(CLD, 0, 1, 0));
      while (exp_q.size() != 0) begin
         tick(in_q.pop_front());
         e = exp_q.pop_front();
         n_chk++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL obstruction_open[%0d]: got %b expected %b", i, got(), e);
         end
         i++;
      end
   endtask

   task automatic test_weight_closed();
      logic [4:0] e;
      int i = 0;
      sched(WLE, E(CLD, 0, 0, 0));
      sched(WLE, E(CLD, 0, 0, 0));
      sched(I0,  E(CLD, 0, 1, 0));
      sched(SOS, E(CLD, 0, 0, 0));
      sched(I0,  E(CLD, 0, 1, 0));
      sched(DEP, E(CLD, 0, 1, 0));
      sched(OBS, E(CLD, 0, 1, 0));
      while (exp_q.size() != 0) begin
         tick(in_q.pop_front());
         e = exp_q.pop_front();
         n_chk++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL weight_closed[%0d]: got %b expected %b", i, got(), e);
         end
         i++;
      end
   endtask

   task automatic test_arrive_depart();
      logic [4:0] e;
      int i = 0;
      sched(ARR | DEP, E(OPG, 0, 0, 0));
      sched(OBS,       E(OPG, 0, 0, 0));
      repeat (4) sched(I0, E(OPN, 1, 0, 0));
      repeat (2) sched(I0, E(CLG, 0, 0, 0));
      sched(I0, E(CLD, 0, 1, 0));
      while (exp_q.size() != 0) begin
         tick(in_q.pop_front());
         e = exp_q.pop_front();
         n_chk++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL arrive_depart[%0d]: got %b expected %b", i, got(), e);
         end
         i++;
      end
   endtask

   task automatic test_reopen_fault();
      logic [4:0] e;
      int i = 0;
      logic f;
      sched(ARR, E(OPG, 0, 0, 0));
      sched(I0,  E(OPG, 0, 0, 0));
      repeat (4) sched(I0, E(OPN, 1, 0, 0));
      sched(I0, E(CLG, 0, 0, 0));
      for (int k = 1; k <= 3; k++) begin
         f = (k == 3);
         sched(OBS, E(OPG, 0, 0, f));
         sched(I0,  E(OPG, 0, 0, f));
         repeat (4) sched(I0, E(OPN, 1, 0, f));
         if (k < 3) sched(I0, E(CLG, 0, 0, 0));
      end
      // The faulted door must stay open whatever the inputs do.
      repeat (4) sched(I0, E(OPN, 1, 0, 1));
      sched(OBS, E(OPN, 1, 0, 1));
      sched(ARR, E(OPN, 1, 0, 1));
      repeat (3) sched(I0, E(OPN, 1, 0, 1));
      while (exp_q.size() != 0) begin
         tick(in_q.pop_front());
         e = exp_q.pop_front();
         n_chk++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL reopen_fault[%0d]: got %b expected %b", i, got(), e);
         end
         i++;
      end
   endtask

   // Entered with the door parked open by the fault.
   task automatic test_reset_mid_open();
      logic [4:0] e;
      #2;
      button_reset = 1'b1;
      exp_q.push_back(E(CLD, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (got() !== e) begin
         n_fail++;
         $display("FAIL reset_mid_open: got %b expected %b", got(), e);
      end
      exp_q.push_back(E(CLD, 0, 1, 0));
      @(negedge door_clk);
      button_reset = 1'b0;
      {arrived, depart_req, obstruction, weight_limit_exceeded, sos_mode} = I0;
      @(posedge door_clk);
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (got() !== e) begin
         n_fail++;
         $display("FAIL reset_mid_open_release: got %b expected %b", got(), e);
      end
   endtask

   // Reset during closing, then a new arrival on the first edge after release.
   task automatic test_back_to_back();
      logic [4:0] e;
      int i = 0;
      sched(ARR, E(OPG, 0, 0, 0));
      sched(I0,  E(OPG, 0, 0, 0));
      repeat (4) sched(I0, E(OPN, 1, 0, 0));
      sched(I0, E(CLG, 0, 0, 0));
      while (exp_q.size() != 0) begin
         tick(in_q.pop_front());
         e = exp_q.pop_front();
         n_chk++;
         if (got() !== e) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got %b expected %b", i, got(), e);
         end
         i++;
      end
      #2;
      button_reset = 1'b1;
      exp_q.push_back(E(CLD, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (got() !== e) begin
         n_fail++;
         $display("FAIL reset_mid_closing: got %b expected %b", got(), e);
      end
      exp_q.push_back(E(OPG, 0, 0, 0));
      @(negedge door_clk);
      button_reset = 1'b0;
      {arrived, depart_req, obstruction, weight_limit_exceeded, sos_mode} = ARR;
      @(posedge door_clk);
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (got() !== e) begin
         n_fail++;
         $display("FAIL back_to_back_arrive: got %b expected %b", got(), e);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cycle();
      test_obstruction_open();
      test_weight_closed();
      test_arrive_depart();
      test_reopen_fault();
      test_reset_mid_open();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
